// File: rtl/filter_vec_pipe_if.sv
// rtl/filter_vec_pipe_if.sv - stream, coefficient and status signals of filter_vec_pipe
interface filter_vec_pipe_if #(
   parameter int LANES = 3,
   parameter int WIDTH = 18
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_sof;
   logic [1:0]               in_mode;
   logic [LANES*WIDTH-1:0]   in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LANES*WIDTH-1:0]   out_data;
   logic                     cfg_we;
   logic [7:0]               cfg_k0;
   logic [7:0]               cfg_k1;
   logic [7:0]               cfg_k2;
   logic [31:0]              beat_count;

   modport master (
      output in_valid, in_sof, in_mode, in_data, out_ready,
      output cfg_we, cfg_k0, cfg_k1, cfg_k2,
      input  in_ready, out_valid, out_data, beat_count
   );

   modport slave (
      input  in_valid, in_sof, in_mode, in_data, out_ready,
      input  cfg_we, cfg_k0, cfg_k1, cfg_k2,
      output in_ready, out_valid, out_data, beat_count
   );
endinterface

// File: rtl/filter_vec_pipe.sv
// rtl/filter_vec_pipe.sv - LANES-wide 3-tap horizontal filter pipeline with valid/ready stall
module filter_vec_pipe #(
   parameter int LANES = 3,
   parameter int WIDTH = 18,
   parameter int SHIFT = 2
) (
   input logic              clk,
   input logic              rst,
   filter_vec_pipe_if.slave bus
);
   localparam int PW = WIDTH + 9;
   localparam int SW = WIDTH + 11;
   localparam int DW = LANES * WIDTH;
   localparam logic signed [SW-1:0] SAT_MAX = SW'({WIDTH{1'b1}});

   // Global stall: every stage advances together or holds together.
   logic en;
   logic acc;

   logic signed [7:0] k0;
   logic signed [7:0] k1;
   logic signed [7:0] k2;

   logic [WIDTH-1:0] h1 [LANES];
   logic [WIDTH-1:0] h2 [LANES];

   logic [WIDTH-1:0]    x_in   [LANES];
   logic [WIDTH-1:0]    h1_sel [LANES];
   logic [WIDTH-1:0]    h2_sel [LANES];
   logic signed [PW-1:0] p0_c  [LANES];
   logic signed [PW-1:0] p1_c  [LANES];
   logic signed [PW-1:0] p2_c  [LANES];

   logic                 s1_valid;
   logic [1:0]           s1_mode;
   logic signed [PW-1:0] s1_p0 [LANES];
   logic signed [PW-1:0] s1_p1 [LANES];
   logic signed [PW-1:0] s1_p2 [LANES];
   logic [WIDTH-1:0]     s1_x  [LANES];
   logic [WIDTH-1:0]     s1_h1 [LANES];

   logic                 s2_valid;
   logic [1:0]           s2_mode;
   logic signed [SW-1:0] s2_sum [LANES];
   logic [WIDTH-1:0]     s2_x   [LANES];
   logic [WIDTH-1:0]     s2_h1  [LANES];

   logic signed [SW-1:0] shf    [LANES];
   logic [WIDTH-1:0]     diff   [LANES];
   logic [WIDTH-1:0]     lane_c [LANES];
   logic [DW-1:0]        res_c;

   logic          out_valid_r;
   logic [DW-1:0] out_data_r;
   logic [31:0]   beat_count_r;

   assign en             = ~out_valid_r | bus.out_ready;
   assign acc            = bus.in_valid & en;
   assign bus.in_ready   = en;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_data   = out_data_r;
   assign bus.beat_count = beat_count_r;

   // Tap selection (start of line replicates x into both taps) and the three products.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         x_in[i]   = bus.in_data[i*WIDTH +: WIDTH];
         h1_sel[i] = bus.in_sof ? x_in[i] : h1[i];
         h2_sel[i] = bus.in_sof ? x_in[i] : h2[i];
         p0_c[i]   = PW'(k0) * PW'($signed({1'b0, h2_sel[i]}));
         p1_c[i]   = PW'(k1) * PW'($signed({1'b0, h1_sel[i]}));
         p2_c[i]   = PW'(k2) * PW'($signed({1'b0, x_in[i]}));
      end
   end

   // Coefficient registers; a beat accepted on the write edge still sees the old values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k0 <= 8'sd1;
         k1 <= 8'sd2;
         k2 <= 8'sd1;
      end else if (bus.cfg_we) begin
         k0 <= $signed(bus.cfg_k0);
         k1 <= $signed(bus.cfg_k1);
         k2 <= $signed(bus.cfg_k2);
      end
   end

   // Per-lane tap history, advanced on every accepted beat regardless of mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            h1[i] <= '0;
            h2[i] <= '0;
         end
      end else if (acc) begin
         for (int i = 0; i < LANES; i++) begin
            h1[i] <= x_in[i];
            h2[i] <= h1_sel[i];
         end
      end
   end

   // Stage 1: capture products, raw sample, selected x[n-1], mode and valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 2'd0;
         for (int i = 0; i < LANES; i++) begin
            s1_p0[i] <= '0;
            s1_p1[i] <= '0;
            s1_p2[i] <= '0;
            s1_x[i]  <= '0;
            s1_h1[i] <= '0;
         end
      end else if (en) begin
         s1_valid <= acc;
         s1_mode  <= bus.in_mode;
         for (int i = 0; i < LANES; i++) begin
            s1_p0[i] <= p0_c[i];
            s1_p1[i] <= p1_c[i];
            s1_p2[i] <= p2_c[i];
            s1_x[i]  <= x_in[i];
            s1_h1[i] <= h1_sel[i];
         end
      end
   end

   // Stage 2: widen and add the three products.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_mode  <= 2'd0;
         for (int i = 0; i < LANES; i++) begin
            s2_sum[i] <= '0;
            s2_x[i]   <= '0;
            s2_h1[i]  <= '0;
         end
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         for (int i = 0; i < LANES; i++) begin
            s2_sum[i] <= SW'(s1_p0[i]) + SW'(s1_p1[i]) + SW'(s1_p2[i]);
            s2_x[i]   <= s1_x[i];
            s2_h1[i]  <= s1_h1[i];
         end
      end
   end

   // Stage 3 datapath: normalise and clamp the FIR sum, edge magnitude, or pass x through.
   always_comb begin
      res_c = '0;
      for (int i = 0; i < LANES; i++) begin
         shf[i]  = s2_sum[i] >>> SHIFT;
         diff[i] = (s2_x[i] >= s2_h1[i]) ? (s2_x[i] - s2_h1[i]) : (s2_h1[i] - s2_x[i]);
         case (s2_mode)
            2'd1: begin
               if (shf[i][SW-1])
                  lane_c[i] = '0;
               else if (shf[i] > SAT_MAX)
                  lane_c[i] = '1;
               else
                  lane_c[i] = shf[i][WIDTH-1:0];
            end
            2'd2:    lane_c[i] = diff[i];
            default: lane_c[i] = s2_x[i];
         endcase
         res_c[i*WIDTH +: WIDTH] = lane_c[i];
      end
   end

   // Stage 3 output register; data only changes when a real beat lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
      end else if (en) begin
         out_valid_r <= s2_valid;
         if (s2_valid)
            out_data_r <= res_c;
      end
   end

   // Count beats consumed downstream; wraps naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         beat_count_r <= '0;
      else if (out_valid_r && bus.out_ready)
         beat_count_r <= beat_count_r + 32'd1;
   end
endmodule

// File: tb/tb_filter_vec_pipe.sv
// tb/tb_filter_vec_pipe.sv - scoreboard bench for filter_vec_pipe
module tb_filter_vec_pipe;
   localparam int LANES = 3;
   localparam int WIDTH = 18;
   localparam int DW    = LANES * WIDTH;

   logic clk = 1'b0;
   logic rst;

   filter_vec_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

   filter_vec_pipe #(.LANES(LANES), .WIDTH(WIDTH), .SHIFT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   exp_beats = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rep(input logic [WIDTH-1:0] v);
      return {LANES{v}};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Present one beat, wait for acceptance, and queue its expected output.
   task automatic send(input logic [DW-1:0] d, input logic sof, input logic [1:0] mode,
                       input logic [DW-1:0] e, input bit push, input bit lat);
      int   n;
      exp_t x;
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_mode  = mode;
      bus.in_data  = d;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: actual in_ready 0 required 1");
      end
      if (push) begin
         x.d   = e;
         x.due = lat ? cyc + 3 : 0;
         q.push_back(x);
         exp_beats++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic cfg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      bus.cfg_k0 = a;
      bus.cfg_k1 = b;
      bus.cfg_k2 = c;
      bus.cfg_we = 1'b1;
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain_timeout: actual %0d pending required 0", name, q.size());
      end
      @(posedge clk);
      #1;
      check({name, "_beat_count"}, bus.beat_count, exp_beats);
   endtask

   // Monitor: compare each delivered beat and the held beat during stalls.
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual data %0h required no beat", bus.out_data);
         end else if (bus.out_ready) begin
            mon_e = q.pop_front();
            check("out_data", bus.out_data, mon_e.d);
            if (mon_e.due != 0)
               check("latency", cyc, mon_e.due);
         end else begin
            check("stall_data", bus.out_data, q[0].d);
            check("stall_in_ready", bus.in_ready, 0);
         end
      end
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_mode   = 2'd0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_k0    = 8'd0;
      bus.cfg_k1    = 8'd0;
      bus.cfg_k2    = 8'd0;

      @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_beat_count", bus.beat_count, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Default coefficients 1/2/1.
      send(rep(18'd100), 1'b1, 2'd1, rep(18'd100), 1, 1);
      send(rep(18'd200), 1'b0, 2'd1, rep(18'd125), 1, 1);
      send(rep(18'd300), 1'b0, 2'd1, rep(18'd200), 1, 1);
      drain("fir");

      // Saturation high and low.
      cfg(8'd0, 8'd0, 8'd127);
      send(rep(18'd262143), 1'b1, 2'd1, rep(18'd262143), 1, 1);
      cfg(8'd0, 8'd0, 8'hFF);
      send(rep(18'd5000), 1'b0, 2'd1, rep(18'd0), 1, 1);
      drain("sat");

      // Edge mode; an unaccepted sof in between must not touch history.
      send(rep(18'd300), 1'b1, 2'd2, rep(18'd0), 1, 1);
      bus.in_sof  = 1'b1;
      bus.in_data = rep(18'd999);
      @(posedge clk);
      #1;
      bus.in_sof  = 1'b0;
      send(rep(18'd250), 1'b0, 2'd2, rep(18'd50), 1, 1);
      send(rep(18'd250), 1'b1, 2'd2, rep(18'd0), 1, 1);
      send(rep(18'd300), 1'b0, 2'd2, rep(18'd50), 1, 1);
      drain("edge");

      // Coefficient write coincident with an accepted beat.
      cfg(8'd1, 8'd2, 8'd1);
      bus.cfg_k0 = 8'd0;
      bus.cfg_k1 = 8'd0;
      bus.cfg_k2 = 8'd4;
      bus.cfg_we = 1'b1;
      send(rep(18'd40), 1'b1, 2'd1, rep(18'd40), 1, 1);
      bus.cfg_we = 1'b0;
      send(rep(18'd40), 1'b0, 2'd1, rep(18'd40), 1, 1);
      send(rep(18'd100), 1'b0, 2'd1, rep(18'd100), 1, 1);
      bus.cfg_k2 = 8'd8;
      bus.cfg_we = 1'b1;
      send(rep(18'd40), 1'b1, 2'd1, rep(18'd40), 1, 1);
      bus.cfg_we = 1'b0;
      send(rep(18'd40), 1'b0, 2'd1, rep(18'd80), 1, 1);
      drain("coef");

      // Backpressure: 8 bypass beats with distinct lanes, 5-cycle stall mid-stream.
      fork
         begin
            logic [DW-1:0] v;
            for (int i = 0; i < 8; i++) begin
               for (int l = 0; l < LANES; l++)
                  v[l*WIDTH +: WIDTH] = WIDTH'(i * 3000 + l * 17 + 5);
               send(v, 1'b0, (i % 2 == 1) ? 2'd3 : 2'd0, v, 1, 0);
            end
         end
         begin
            repeat (4) @(posedge clk);
            #2;
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2;
            bus.out_ready = 1'b1;
         end
      join
      drain("bp");

      // Reset with beats in flight.
      send(rep(18'd7), 1'b1, 2'd1, rep(18'd0), 0, 0);
      send(rep(18'd8), 1'b0, 2'd1, rep(18'd0), 0, 0);
      send(rep(18'd9), 1'b0, 2'd1, rep(18'd0), 0, 0);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_out_data", bus.out_data, 0);
      check("midrst_beat_count", bus.beat_count, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      q.delete();
      exp_beats = 0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      send(rep(18'd64), 1'b1, 2'd1, rep(18'd64), 1, 1);
      send(rep(18'd128), 1'b0, 2'd1, rep(18'd80), 1, 1);
      drain("post_rst");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
